addsub_rr_arbiter: RTL and testbench
====================================

// Module: addsub_rr_arbiter
// PURPOSE
//   Shares one 32-bit Brent-Kung add/sub datapath (adder_subtractor_bk) among NREQ requesters.
//   Round-robin arbitration, valid/ready handshake per requester, one-entry registered result stage.
//   The datapath computes only A+B+cin, so this block forms B^{WIDTH{sub}} and drives cin=sub.
//   Sits between the operand-issuing units and the shared arithmetic unit.
// PARAMETERS
//   NREQ   4    number of requesters (2..8); IDW = $clog2(NREQ)
//   WIDTH  32   operand width; must match the instanced datapath (32)
// PORTS
//   clk        in   1           single clock, all state on rising edge
//   rst_n      in   1           synchronous reset, active-low
//   req_valid  in   NREQ        requester i has an operation pending
//   req_ready  out  NREQ        one-hot grant; op i accepted when req_valid[i]&&req_ready[i]
//   req_sub    in   NREQ        per requester: 0 = A+B, 1 = A-B
//   req_a      in   NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   NREQ*WIDTH  operand B, same packing
//   rsp_valid  out  1           result register holds a valid result
//   rsp_ready  in   1           consumer takes the result when rsp_valid&&rsp_ready
//   rsp_id     out  IDW         index of requester that issued the result
//   rsp_sum    out  WIDTH       A+B or A-B, modulo 2^WIDTH
//   rsp_cout   out  1           carry out (subtract: 1 = no borrow, A>=B unsigned)
//   rsp_ovf    out  1           signed overflow
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, rr_ptr=0.
//     req_ready is 0 throughout any cycle with rst_n=0. Reset mid-operation discards the held result.
//   States: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
//   can_accept = EMPTY | (FULL & rsp_ready)  -- full-throughput drain-and-refill in one cycle.
//   Grant (combinational): if can_accept, req_ready = one-hot of first req_valid[i] searching
//     i = rr_ptr, rr_ptr+1, ... wrapping mod NREQ; else req_ready = 0. req_ready never depends on
//     req_ready of another requester; at most one bit set; never set for a non-valid requester.
//   On accept of requester g: datapath A=req_a[g], B=req_b[g]^{WIDTH{req_sub[g]}}, cin=req_sub[g];
//     next edge: rsp_sum/rsp_cout from datapath, rsp_id=g, rsp_valid=1, rr_ptr=(g+1) mod NREQ.
//   rsp_ovf = (A[W-1]==Bmod[W-1]) & (sum[W-1]!=A[W-1]), Bmod = B after conditional inversion.
//   Latency: accept in cycle N -> rsp_valid=1 from cycle N+1. Throughput 1 op/cycle if rsp_ready=1.
//   Transitions: EMPTY--accept-->FULL; FULL--rsp_ready & no accept-->EMPTY;
//     FULL--rsp_ready & accept-->FULL (new result); FULL--!rsp_ready-->FULL, outputs held stable.
//   rr_ptr changes only on accept. No request accepted -> rr_ptr unchanged.
//   Fairness: a continuously valid requester is granted within NREQ accepts.
//   Requesters must hold req_valid and operands stable until accepted; deasserting before
//     accept is legal (request withdrawn, no side effect).
//   Wrap-around: sum modulo 2^WIDTH; e.g. FFFF_FFFF+1 -> 0, cout=1, ovf=0.
// TESTING
//   1 Reset: rst_n=0 2 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0, all rsp_* = 0.
//   2 Single add: req0 A=5,B=3,sub=0, rsp_ready=1 -> next cycle rsp_sum=8, id=0, cout=0, ovf=0.
//   3 Subtract/borrow: req1 A=3,B=5,sub=1 -> rsp_sum=FFFF_FFFE, cout=0, ovf=0;
//     A=8000_0000,B=1,sub=1 -> sum=7FFF_FFFF, cout=1, ovf=1.
//   4 Round-robin: all 4 valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,... one per cycle.
//   5 Backpressure: rsp_ready=0 with result held, req2 valid -> req_ready=0, rsp_* stable;
//     raise rsp_ready -> same cycle req_ready[2]=1, next cycle new result, no result lost/duplicated.
//   6 Reset mid-op: rst_n=0 while FULL and rsp_ready=0 -> rsp_valid=0 next edge; after release
//     req0 granted first (rr_ptr=0) and held result never appears.

Source files
------------

// File: rtl/addsub_rr_arbiter.sv
// Round-robin arbiter that shares one Brent-Kung add/sub datapath among NREQ requesters.
// It has a one-entry registered result stage that can be drained and refilled in the same cycle.

module adder_subtractor_bk #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int LVL = $clog2(WIDTH);

    logic [WIDTH-1:0] gen_bit;
    logic [WIDTH-1:0] prop_bit;
    logic [WIDTH-1:0] grp_g;
    logic [WIDTH-1:0] grp_p;

    genvar gi;
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign gen_bit[gi]  = a[gi] & b[gi];
        assign prop_bit[gi] = a[gi] ^ b[gi];
    end

    // Carry-in is folded into bit 0, so grp_g[i] ends up as the carry out of bit i.
    always_comb begin
        grp_g    = gen_bit;
        grp_p    = prop_bit;
        grp_g[0] = gen_bit[0] | (prop_bit[0] & cin);
        for (int d = 0; d < LVL; d++) begin
            for (int k = (2 << d) - 1; k < WIDTH; k += (2 << d)) begin
                grp_g[k] = grp_g[k] | (grp_p[k] & grp_g[k - (1 << d)]);
                grp_p[k] = grp_p[k] & grp_p[k - (1 << d)];
            end
        end
        for (int d = LVL - 2; d >= 0; d--) begin
            for (int k = 3 * (1 << d) - 1; k < WIDTH; k += (2 << d)) begin
                grp_g[k] = grp_g[k] | (grp_p[k] & grp_g[k - (1 << d)]);
            end
        end
    end

    assign sum[0] = prop_bit[0] ^ cin;
    for (gi = 1; gi < WIDTH; gi++) begin : g_sum
        assign sum[gi] = prop_bit[gi] ^ grp_g[gi-1];
    end
    assign cout = grp_g[WIDTH-1];
endmodule

module addsub_rr_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 32,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       req_sub,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_ovf
);
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_ovf_q, rsp_ovf_d;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   gnt_id;
    logic             gnt_found;
    int               scan_idx;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] op_a, op_b, dp_sum;
    logic             op_sub, dp_cout;

    // Scan starts at rr_ptr_q and wraps; the first valid requester found wins.
    always_comb begin
        grant     = '0;
        gnt_id    = '0;
        gnt_found = 1'b0;
        scan_idx  = 0;
        for (int off = 0; off < NREQ; off++) begin
            scan_idx = (int'(rr_ptr_q) + off) % NREQ;
            if (!gnt_found && req_valid[scan_idx]) begin
                grant[scan_idx] = 1'b1;
                gnt_id          = IDW'(scan_idx);
                gnt_found       = 1'b1;
            end
        end
    end

    assign can_accept = (state_q == ST_EMPTY) || rsp_ready;
    assign req_ready  = (rst_n && can_accept) ? grant : '0;
    assign accept     = |req_ready;

    always_comb begin
        op_sub = req_sub[gnt_id];
        op_a   = req_a[int'(gnt_id)*WIDTH +: WIDTH];
        op_b   = req_b[int'(gnt_id)*WIDTH +: WIDTH] ^ {WIDTH{op_sub}};
    end

    adder_subtractor_bk #(.WIDTH(WIDTH)) u_dp (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_sub),
        .sum  (dp_sum),
        .cout (dp_cout)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        rsp_id_d   = rsp_id_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        rsp_ovf_d  = rsp_ovf_q;
        if (accept) begin
            state_d    = ST_FULL;
            rr_ptr_d   = IDW'((int'(gnt_id) + 1) % NREQ);
            rsp_id_d   = gnt_id;
            rsp_sum_d  = dp_sum;
            rsp_cout_d = dp_cout;
            rsp_ovf_d  = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (dp_sum[WIDTH-1] != op_a[WIDTH-1]);
        end else if ((state_q == ST_FULL) && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            rr_ptr_q   <= '0;
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            rsp_id_q   <= rsp_id_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_ovf_q  <= rsp_ovf_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;
endmodule

// File: tb/tb_addsub_rr_arbiter.sv
// Testbench for addsub_rr_arbiter. It combines a table of add/sub vectors, a scoreboard queue and a round-robin grant model
// with hand-written backpressure, mid-operation reset and rotation sequences.

module tb_addsub_rr_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req_valid, req_ready, req_sub;
    logic [NREQ*W-1:0] req_a, req_b;
    logic            rsp_valid, rsp_ready;
    logic [1:0]      rsp_id;
    logic [W-1:0]    rsp_sum;
    logic            rsp_cout, rsp_ovf;

    always #5 clk = ~clk;

    addsub_rr_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sub   (req_sub),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    typedef struct {
        int         req;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    vec_t vecs [8];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;
    int   rr_model = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub);
        exp_t   e;
        longint sa, sbv, r;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        r   = sub ? (sa - sbv) : (sa + sbv);
        e.id   = 2'(id);
        e.sum  = sub ? (a - b) : (a + b);
        e.cout = sub ? (a >= b) : ((64'(a) + 64'(b)) > 64'h0000_0000_FFFF_FFFF);
        e.ovf  = (r > longint'(32'sh7FFF_FFFF)) || (r < longint'(32'sh8000_0000));
        return e;
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic sub);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_sub[i]      = sub;
    endtask

    // One clock cycle: check grant and response mid-cycle, update scoreboard, cross the edge.
    task automatic tick();
        logic [NREQ-1:0] exp_rdy;
        int g, idx;
        #1;
        exp_rdy = '0;
        g = -1;
        for (int off = 0; off < NREQ; off++) begin
            idx = (rr_model + off) % NREQ;
            if (g < 0 && req_valid[idx]) g = idx;
        end
        if (g >= 0 && rst_n && (sb.size() == 0 || rsp_ready)) exp_rdy[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        chk("rsp_valid", 64'(rsp_valid), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("rsp_fields", {28'd0, rsp_id, rsp_sum, rsp_cout, rsp_ovf},
                {28'd0, sb[0].id, sb[0].sum, sb[0].cout, sb[0].ovf});
        end
        if (rst_n) begin
            if (sb.size() != 0 && rsp_ready) begin
                $display("txn rsp id=%0d sum=%h cout=%b ovf=%b", rsp_id, rsp_sum, rsp_cout, rsp_ovf);
                void'(sb.pop_front());
            end
            if (exp_rdy != '0) begin
                sb.push_back(model(g, req_a[g*W +: W], req_b[g*W +: W], req_sub[g]));
                rr_model = (g + 1) % NREQ;
            end
        end else begin
            sb.delete();
            rr_model = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{0, 32'd5,          32'd3,          1'b0, 32'd8,          1'b0, 1'b0};
        vecs[1] = '{1, 32'd3,          32'd5,          1'b1, 32'hFFFF_FFFE,  1'b0, 1'b0};
        vecs[2] = '{2, 32'h8000_0000,  32'd1,          1'b1, 32'h7FFF_FFFF,  1'b1, 1'b1};
        vecs[3] = '{3, 32'hFFFF_FFFF,  32'd1,          1'b0, 32'h0000_0000,  1'b1, 1'b0};
        vecs[4] = '{0, 32'h7FFF_FFFF,  32'd1,          1'b0, 32'h8000_0000,  1'b0, 1'b1};
        vecs[5] = '{1, 32'd5,          32'd5,          1'b1, 32'h0000_0000,  1'b1, 1'b0};
        vecs[6] = '{2, 32'h1234_5678,  32'h1111_1111,  1'b0, 32'h2345_6789,  1'b0, 1'b0};
        vecs[7] = '{3, 32'h8000_0000,  32'h8000_0000,  1'b0, 32'h0000_0000,  1'b1, 1'b1};

        // Reset held for two edges with every requester asking.
        rst_n     = 1'b0;
        req_valid = '1;
        req_sub   = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i + 1), 32'(i + 2), 1'b0);
        #1;
        chk("reset_ready_pre", 64'(req_ready), 64'd0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk("reset_ready", 64'(req_ready), 64'd0);
            chk("reset_rsp", {28'd0, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf}, 64'd0);
        end
        rst_n     = 1'b1;
        req_valid = '0;
        @(negedge clk);

        // Table of single operations, each on its own requester.
        for (int i = 0; i < 8; i++) begin
            set_req(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].sub);
            req_valid = NREQ'(1 << vecs[i].req);
            rsp_ready = 1'b1;
            tick();
            req_valid = '0;
            #1;
            chk("vec_valid", 64'(rsp_valid), 64'd1);
            chk("vec_result", {28'd0, rsp_id, rsp_sum, rsp_cout, rsp_ovf},
                {28'd0, 2'(vecs[i].req), vecs[i].sum, vecs[i].cout, vecs[i].ovf});
            tick();
        end

        // Backpressure: the result is held while req2 waits, then drain and refill happen in the same cycle.
        set_req(0, 32'd100, 32'd50, 1'b0);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        tick();
        set_req(2, 32'd9, 32'd4, 1'b1);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        chk("bp_ready_blocked", 64'(req_ready), 64'd0);
        chk("bp_held_sum", 64'(rsp_sum), 64'd150);
        repeat (3) tick();
        rsp_ready = 1'b1;
        #1;
        chk("bp_release_grant", 64'(req_ready), 64'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("bp_new_result", {30'd0, rsp_id, rsp_sum}, {30'd0, 2'd2, 32'd5});
        tick();

        // Reset while FULL and stalled; the held result must vanish and rr restart at 0.
        set_req(1, 32'hDEAD_0000, 32'd1, 1'b0);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        #1;
        chk("midreset_valid", 64'(rsp_valid), 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i * 100 + 7), 32'(i + 1), i[0]);
        req_valid = '1;
        rsp_ready = 1'b1;
        #1;
        chk("rr_first_after_reset", 64'(req_ready), 64'b0001);

        // Continuous requests: grants rotate one per cycle.
        for (int k = 0; k < 8; k++) begin
            tick();
            #1;
            chk("rr_id", 64'(rsp_id), 64'(k % NREQ));
        end
        req_valid = '0;
        tick();
        tick();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
